// File: rtl/share_unmasker_if.sv
// Share-pair input stream and unmasked-word output handshake of share_unmasker.
// Latency: none, signal bundle only.
// Backpressure: o_ready stalls the pair stream; i_ready stalls the output word.
// Ports: i_y0/i_y1/i_valid/o_ready/i_clear/i_rand on the share side;
//        o_data/o_valid/i_ready on the output side.
interface share_unmasker_if #(
   parameter int WIDTH = 8
);
   logic             i_y0;
   logic             i_y1;
   logic             i_valid;
   logic             o_ready;
   logic             i_clear;
   logic [WIDTH-1:0] i_rand;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic             i_ready;

   // Block side.
   modport slave (
      input  i_y0, i_y1, i_valid, i_clear, i_rand, i_ready,
      output o_ready, o_data, o_valid
   );

   // Environment side: upstream gates plus downstream consumer.
   modport master (
      output i_y0, i_y1, i_valid, i_clear, i_rand, i_ready,
      input  o_ready, o_data, o_valid
   );
endinterface

// File: rtl/share_unmasker.sv
// Collects WIDTH masked share-bit pairs LSB-first, refreshes both shares, then unmasks.
// Latency: o_valid rises two edges after the edge that accepts the last pair.
// Backpressure: o_ready low outside COLLECT; output word held in HOLD until i_ready.
// Ports: clk, rst_n (async active-low), bus (share_unmasker_if.slave).
module share_unmasker #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   share_unmasker_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      REFRESH = 2'd1,
      UNMASK  = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sh0_q;
   logic [WIDTH-1:0] sh1_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             rdy;

   // Control only: a pair is taken in COLLECT unless a clear wins the cycle.
   logic in_collect;
   logic accept;
   logic clear;
   assign in_collect = (state_q == COLLECT);
   assign clear      = in_collect && bus.i_clear;
   assign accept     = in_collect && bus.i_valid && !bus.i_clear;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= COLLECT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      rdy     = 1'b0;
      case (state_q)
         COLLECT: begin
            rdy = 1'b1;
            if (accept && (cnt_q == CNT_LAST)) state_d = REFRESH;
         end
         REFRESH: state_d = UNMASK;
         UNMASK:  state_d = HOLD;
         HOLD:    if (bus.i_ready) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // ---------------- pair counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // ---------------- share registers ----------------
   // Each share lives in its own process with no logic touching the other
   // share, so the two never meet ahead of the unmask XOR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh0_q <= '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (clear)       sh0_q <= '0;
               else if (accept) sh0_q <= {bus.i_y0, sh0_q[WIDTH-1:1]};
            end
            REFRESH: sh0_q <= sh0_q ^ bus.i_rand;
            UNMASK:  sh0_q <= '0;
            default: sh0_q <= sh0_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh1_q <= '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (clear)       sh1_q <= '0;
               else if (accept) sh1_q <= {bus.i_y1, sh1_q[WIDTH-1:1]};
            end
            REFRESH: sh1_q <= sh1_q ^ bus.i_rand;
            UNMASK:  sh1_q <= '0;
            default: sh1_q <= sh1_q;
         endcase
      end
   end

   // ---------------- output word ----------------
   // The only place the shares are combined; result goes straight into a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (state_q == UNMASK) begin
         data_q <= sh0_q ^ sh1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else if (state_q == UNMASK) begin
         valid_q <= 1'b1;
      end else if ((state_q == HOLD) && bus.i_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.o_ready = rdy;
   assign bus.o_data  = data_q;
   assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_share_unmasker.sv
// Directed bench for share_unmasker: vector table plus reset/clear/back-to-back sequences.
// Latency: checks o_valid two edges after the last accepted pair.
// Backpressure: exercises HOLD stalls and pairs presented while o_ready is low.
module tb_share_unmasker;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cyc;
   int   last_vld_cyc;

   share_unmasker_if #(.WIDTH(W)) bus ();

   share_unmasker #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [7:0] s0;
      logic [7:0] s1;
      logic [7:0] rnd;
      int         hold;
      bit         gaps;
      bit         present;
      logic [7:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present n pairs LSB-first; optional random idle cycles between pairs.
   task automatic feed(input logic [7:0] s0, input logic [7:0] s1, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.i_valid = 1'b0;
            bus.i_y0    = 1'($urandom);
            bus.i_y1    = 1'($urandom);
            step();
         end
         bus.i_y0    = s0[i];
         bus.i_y1    = s1[i];
         bus.i_valid = 1'b1;
         step();
      end
      bus.i_valid = 1'b0;
   endtask

   // Starts at the negedge after the final accept edge E.
   task automatic finish(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] rnd,
                         input logic [7:0] exp, input int hold, input bit present);
      chk("refresh_ready", 32'(bus.o_ready), 32'd0);
      chk("refresh_valid", 32'(bus.o_valid), 32'd0);
      chk("collected_sh0", 32'(dut.sh0_q), 32'(s0));
      chk("collected_sh1", 32'(dut.sh1_q), 32'(s1));
      if (present) begin
         bus.i_valid = 1'b1;
         bus.i_y0    = 1'b1;
         bus.i_y1    = 1'b0;
      end
      step();
      // UNMASK cycle: refreshed shares visible; i_rand now must be ignored.
      bus.i_rand = 8'($urandom);
      chk("refreshed_sh0", 32'(dut.sh0_q), 32'(s0 ^ rnd));
      chk("refreshed_sh1", 32'(dut.sh1_q), 32'(s1 ^ rnd));
      chk("unmask_valid", 32'(bus.o_valid), 32'd0);
      step();
      chk("hold_valid", 32'(bus.o_valid), 32'd1);
      chk("hold_data", 32'(bus.o_data), 32'(exp));
      chk("hold_ready", 32'(bus.o_ready), 32'd0);
      last_vld_cyc = cyc;
      for (int k = 1; k < hold; k++) begin
         step();
         chk("stall_valid", 32'(bus.o_valid), 32'd1);
         chk("stall_data", 32'(bus.o_data), 32'(exp));
         chk("stall_ready", 32'(bus.o_ready), 32'd0);
      end
      bus.i_ready = 1'b1;
      step();
      bus.i_valid = 1'b0;
      chk("done_valid", 32'(bus.o_valid), 32'd0);
      chk("done_ready", 32'(bus.o_ready), 32'd1);
      chk("done_data_kept", 32'(bus.o_data), 32'(exp));
      chk("done_cnt", 32'(dut.cnt_q), 32'd0);
   endtask

   task automatic run_word(input vec_t v);
      bus.i_rand  = v.rnd;
      bus.i_ready = (v.hold == 0);
      feed(v.s0, v.s1, W, v.gaps);
      finish(v.s0, v.s1, v.rnd, v.exp, v.hold, v.present);
   endtask

   vec_t tbl[3];
   vec_t v;
   int   prev;

   initial begin
      checks = 0; errors = 0; cyc = 0; last_vld_cyc = 0;
      rst_n = 1'b0;
      bus.i_y0 = 1'b0; bus.i_y1 = 1'b0; bus.i_valid = 1'b0;
      bus.i_clear = 1'b0; bus.i_rand = '0; bus.i_ready = 1'b0;

      tbl[0] = '{s0:8'h99, s1:8'h3C, rnd:8'h5A, hold:0, gaps:1'b0, present:1'b0, exp:8'hA5};
      tbl[1] = '{s0:8'h6E, s1:8'hCB, rnd:8'h33, hold:5, gaps:1'b1, present:1'b1, exp:8'hA5};
      tbl[2] = '{s0:8'h12, s1:8'h34, rnd:8'hF0, hold:1, gaps:1'b0, present:1'b0, exp:8'h26};

      repeat (2) @(negedge clk);
      chk("reset_ready", 32'(bus.o_ready), 32'd1);
      chk("reset_valid", 32'(bus.o_valid), 32'd0);
      chk("reset_data", 32'(bus.o_data), 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 3; i++) run_word(tbl[i]);

      // Random splits of 0xA5 with random refresh masks.
      for (int i = 0; i < 16; i++) begin
         v.s0 = 8'($urandom);
         v.s1 = v.s0 ^ 8'hA5;
         v.rnd = 8'($urandom);
         v.hold = 0; v.gaps = 1'b0; v.present = 1'b0; v.exp = 8'hA5;
         run_word(v);
      end

      // Clear together with a valid 5th pair: pair dropped, word restarts.
      bus.i_ready = 1'b1;
      feed(8'hFF, 8'h00, 4, 1'b0);
      chk("pre_clear_cnt", 32'(dut.cnt_q), 32'd4);
      bus.i_y0 = 1'b1; bus.i_y1 = 1'b1; bus.i_valid = 1'b1; bus.i_clear = 1'b1;
      step();
      bus.i_clear = 1'b0; bus.i_valid = 1'b0;
      chk("clear_cnt", 32'(dut.cnt_q), 32'd0);
      chk("clear_sh0", 32'(dut.sh0_q), 32'd0);
      chk("clear_sh1", 32'(dut.sh1_q), 32'd0);
      chk("clear_ready", 32'(bus.o_ready), 32'd1);
      v = '{s0:8'h3A, s1:8'h35, rnd:8'hC7, hold:0, gaps:1'b0, present:1'b0, exp:8'h0F};
      run_word(v);

      // Asynchronous reset mid-word.
      feed(8'hAA, 8'h55, 3, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_mid_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_mid_data", 32'(bus.o_data), 32'd0);
      chk("rst_mid_cnt", 32'(dut.cnt_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Asynchronous reset while holding an output word.
      bus.i_ready = 1'b0;
      feed(8'h0F, 8'h55, W, 1'b0);
      step();
      step();
      chk("pre_rst_hold_valid", 32'(bus.o_valid), 32'd1);
      chk("pre_rst_hold_data", 32'(bus.o_data), 32'h5A);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_hold_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_hold_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_hold_data", 32'(bus.o_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      v = '{s0:8'hC3, s1:8'h3C, rnd:8'h81, hold:0, gaps:1'b0, present:1'b0, exp:8'hFF};
      run_word(v);

      // Back-to-back words with i_ready high: one word every W+3 cycles.
      tbl[0] = '{s0:8'h55, s1:8'h54, rnd:8'h0D, hold:0, gaps:1'b0, present:1'b0, exp:8'h01};
      tbl[1] = '{s0:8'h12, s1:8'h92, rnd:8'hE4, hold:0, gaps:1'b0, present:1'b0, exp:8'h80};
      tbl[2] = '{s0:8'h77, s1:8'h77, rnd:8'h6B, hold:0, gaps:1'b0, present:1'b0, exp:8'h00};
      for (int j = 0; j < 3; j++) begin
         prev = last_vld_cyc;
         run_word(tbl[j]);
         if (j > 0) chk("b2b_period", 32'(last_vld_cyc - prev), 32'(W + 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
